dllp_rx_decode: RTL and testbench

- Receive-side DLLP checker/decoder; consumes the DLLP AXIS output of the RX user demux.
- Reassembles each 6-byte DLLP from 32-bit beats, checks the 16-bit DLLP CRC, and decodes the DLLP type.
- Emits single-cycle Ack/Nak and flow-control (InitFC1/InitFC2/UpdateFC) event strobes to the retry-buffer and flow-control-tracking logic.

---
 rtl/dllp_rx_decode.sv | 260 ++++++++++++++++++++++++++
 tb/tb_dllp_rx_decode.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dllp_rx_decode.sv
// dllp_rx_decode: receive-side DLLP checker/decoder.
// Reassembles 6-byte DLLPs from 32-bit AXIS beats, checks the DLLP CRC-16,
// decodes the type and emits one-cycle Ack/Nak and flow-control strobes.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   link_status_i          data-link state; DL_INACTIVE suppresses all strobes
//   s_axis_*               DLLP byte stream from the RX demux (byte0 in [7:0])
//   s_axis_tready          always 1 outside reset
//   ack_nak_*_o            Ack/Nak strobe, type and sequence number
//   fc_*_o                 FC strobe plus fields held from the last good FC DLLP
//   crc_err_o, len_err_o   CRC mismatch / byte count != 6 strobes
//
// Optional feature (macro DLLP_RX_STATS_EN): adds saturating 16-bit counters
// ack_cnt_o, nak_cnt_o, fc_cnt_o, err_cnt_o.

package dllp_rx_decode_pkg;
    typedef enum logic [1:0] {
        DL_INACTIVE = 2'd0,
        DL_INIT     = 2'd1,
        DL_ACTIVE   = 2'd2
    } pcie_dl_status_e;
endpackage

module dllp_rx_decode
    import dllp_rx_decode_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned USER_WIDTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  pcie_dl_status_e       link_status_i,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic                  s_axis_tready,
    output logic                  ack_nak_valid_o,
    output logic                  ack_nak_is_nak_o,
    output logic [11:0]           ack_nak_seq_o,
    output logic                  fc_valid_o,
    output logic [1:0]            fc_kind_o,
    output logic [1:0]            fc_class_o,
    output logic [2:0]            fc_vc_o,
    output logic [7:0]            fc_hdr_o,
    output logic [11:0]           fc_data_o,
    output logic                  crc_err_o,
    output logic                  len_err_o
`ifdef DLLP_RX_STATS_EN
    ,
    output logic [15:0]           ack_cnt_o,
    output logic [15:0]           nak_cnt_o,
    output logic [15:0]           fc_cnt_o,
    output logic [15:0]           err_cnt_o
`endif
);

    localparam int unsigned DLLP_BYTES = 6;
    localparam int unsigned CRC_BYTES  = 4;
    localparam int unsigned ACC_MAX    = 8;
    localparam logic [15:0] CRC_POLY   = 16'h100B;
    localparam logic [15:0] CRC_SEED   = 16'hFFFF;

    typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_FINISH} state_e;

    state_e                        state_q, state_d;
    logic [DLLP_BYTES-1:0][7:0]    byte_q, byte_d;
    logic [3:0]                    cnt_q, cnt_d;
    logic [15:0]                   crc_q, crc_d;
    logic                          beat_c, eval_c, link_up_c;
    logic [15:0]                   crc_exp_c;
    logic                          fc_hit_c;
    logic [1:0]                    fc_kind_c, fc_cls_c;

    logic        an_v_q, an_v_d, an_nak_q, an_nak_d;
    logic [11:0] an_seq_q, an_seq_d;
    logic        fc_v_q, fc_v_d;
    logic [1:0]  fc_kind_q, fc_kind_d, fc_cls_q, fc_cls_d;
    logic [2:0]  fc_vc_q, fc_vc_d;
    logic [7:0]  fc_hdr_q, fc_hdr_d;
    logic [11:0] fc_data_q, fc_data_d;
    logic        crc_err_q, crc_err_d, len_err_q, len_err_d;

    logic unused_tuser;
    assign unused_tuser = ^s_axis_tuser[USER_WIDTH-1:1];

    // One CRC-16 step over a byte, LSB first.
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[15] ^ b[i]) ? ({r[14:0], 1'b0} ^ CRC_POLY) : {r[14:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    assign s_axis_tready = ~rst_i;
    assign beat_c        = s_axis_tvalid & s_axis_tuser[0];
    assign link_up_c     = (link_status_i != DL_INACTIVE);

    // Next-state and byte/CRC accumulation.
    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        eval_c  = 1'b0;
        // Outside COLLECT the next beat is always the first of a fresh DLLP.
        if (state_q != ST_COLLECT) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            crc_d   = CRC_SEED;
        end
        if (beat_c) begin
            for (int j = 0; j < int'(KEEP_WIDTH); j++) begin
                if (s_axis_tkeep[j]) begin
                    if (cnt_d < 4'(DLLP_BYTES)) byte_d[cnt_d[2:0]] = s_axis_tdata[8*j +: 8];
                    if (cnt_d < 4'(CRC_BYTES))  crc_d = crc_byte(crc_d, s_axis_tdata[8*j +: 8]);
                    if (cnt_d < 4'(ACC_MAX))    cnt_d = cnt_d + 4'd1;
                end
            end
            state_d = s_axis_tlast ? ST_FINISH : ST_COLLECT;
            eval_c  = s_axis_tlast;
        end
    end

    // FC type nibble -> kind/class.
    always_comb begin
        fc_hit_c  = 1'b1;
        fc_kind_c = 2'd0;
        fc_cls_c  = 2'd0;
        case (byte_d[0][7:4])
            4'h4, 4'h5, 4'h6: begin fc_kind_c = 2'd0; fc_cls_c = 2'(byte_d[0][7:4] - 4'h4); end
            4'hC, 4'hD, 4'hE: begin fc_kind_c = 2'd1; fc_cls_c = 2'(byte_d[0][7:4] - 4'hC); end
            4'h8, 4'h9, 4'hA: begin fc_kind_c = 2'd2; fc_cls_c = 2'(byte_d[0][7:4] - 4'h8); end
            default:          fc_hit_c = 1'b0;
        endcase
    end

    // DLLP evaluation on the tlast beat so strobes land during ST_FINISH.
    always_comb begin
        an_v_d    = 1'b0;
        an_nak_d  = an_nak_q;
        an_seq_d  = an_seq_q;
        fc_v_d    = 1'b0;
        fc_kind_d = fc_kind_q;
        fc_cls_d  = fc_cls_q;
        fc_vc_d   = fc_vc_q;
        fc_hdr_d  = fc_hdr_q;
        fc_data_d = fc_data_q;
        crc_err_d = 1'b0;
        len_err_d = 1'b0;
        // Transmitted CRC is the complemented remainder, bit-reversed per byte.
        crc_exp_c = {rev8(~crc_d[15:8]), rev8(~crc_d[7:0])};
        if (eval_c && link_up_c) begin
            if (cnt_d != 4'(DLLP_BYTES)) begin
                len_err_d = 1'b1;
            end else if (crc_exp_c != {byte_d[4], byte_d[5]}) begin
                crc_err_d = 1'b1;
            end else if (byte_d[0] == 8'h00 || byte_d[0] == 8'h10) begin
                an_v_d   = 1'b1;
                an_nak_d = byte_d[0][4];
                an_seq_d = {byte_d[2][3:0], byte_d[3]};
            end else if (fc_hit_c) begin
                fc_v_d    = 1'b1;
                fc_kind_d = fc_kind_c;
                fc_cls_d  = fc_cls_c;
                fc_vc_d   = byte_d[0][2:0];
                fc_hdr_d  = {byte_d[1][5:0], byte_d[2][7:6]};
                fc_data_d = {byte_d[2][3:0], byte_d[3]};
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            byte_q    <= '0;
            cnt_q     <= '0;
            crc_q     <= CRC_SEED;
            an_v_q    <= 1'b0;
            an_nak_q  <= 1'b0;
            an_seq_q  <= '0;
            fc_v_q    <= 1'b0;
            fc_kind_q <= '0;
            fc_cls_q  <= '0;
            fc_vc_q   <= '0;
            fc_hdr_q  <= '0;
            fc_data_q <= '0;
            crc_err_q <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            an_v_q    <= an_v_d;
            an_nak_q  <= an_nak_d;
            an_seq_q  <= an_seq_d;
            fc_v_q    <= fc_v_d;
            fc_kind_q <= fc_kind_d;
            fc_cls_q  <= fc_cls_d;
            fc_vc_q   <= fc_vc_d;
            fc_hdr_q  <= fc_hdr_d;
            fc_data_q <= fc_data_d;
            crc_err_q <= crc_err_d;
            len_err_q <= len_err_d;
        end
    end

    assign ack_nak_valid_o  = an_v_q;
    assign ack_nak_is_nak_o = an_nak_q;
    assign ack_nak_seq_o    = an_seq_q;
    assign fc_valid_o       = fc_v_q;
    assign fc_kind_o        = fc_kind_q;
    assign fc_class_o       = fc_cls_q;
    assign fc_vc_o          = fc_vc_q;
    assign fc_hdr_o         = fc_hdr_q;
    assign fc_data_o        = fc_data_q;
    assign crc_err_o        = crc_err_q;
    assign len_err_o        = len_err_q;

`ifdef DLLP_RX_STATS_EN
    logic [15:0] ack_cnt_q, nak_cnt_q, fc_cnt_q, err_cnt_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    // Saturating event counters, fed by the same values that load the strobes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_cnt_q <= '0;
            nak_cnt_q <= '0;
            fc_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            ack_cnt_q <= sat_inc(ack_cnt_q, an_v_d & ~an_nak_d);
            nak_cnt_q <= sat_inc(nak_cnt_q, an_v_d & an_nak_d);
            fc_cnt_q  <= sat_inc(fc_cnt_q, fc_v_d);
            err_cnt_q <= sat_inc(err_cnt_q, crc_err_d | len_err_d);
        end
    end

    assign ack_cnt_o = ack_cnt_q;
    assign nak_cnt_o = nak_cnt_q;
    assign fc_cnt_o  = fc_cnt_q;
    assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_dllp_rx_decode.sv
// Testbench for dllp_rx_decode: directed cases with literal expectations plus
// randomized DLLP traffic compared every cycle against a queue-based model.
module tb_dllp_rx_decode;
    import dllp_rx_decode_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    pcie_dl_status_e link = DL_ACTIVE;
    logic [31:0]     tdata = '0;
    logic [3:0]      tkeep = '0;
    logic            tvalid = 1'b0;
    logic            tlast = 1'b0;
    logic [1:0]      tuser = 2'b01;

    logic        tready, an_v, an_nak, fc_v, crc_err, len_err;
    logic [11:0] an_seq, fc_data;
    logic [1:0]  fc_kind, fc_cls;
    logic [2:0]  fc_vc;
    logic [7:0]  fc_hdr;
`ifdef DLLP_RX_STATS_EN
    logic [15:0] ack_cnt, nak_cnt, fc_cnt, err_cnt;
`endif

    dllp_rx_decode dut (
        .clk_i(clk), .rst_i(rst), .link_status_i(link),
        .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tvalid(tvalid),
        .s_axis_tlast(tlast), .s_axis_tuser(tuser), .s_axis_tready(tready),
        .ack_nak_valid_o(an_v), .ack_nak_is_nak_o(an_nak), .ack_nak_seq_o(an_seq),
        .fc_valid_o(fc_v), .fc_kind_o(fc_kind), .fc_class_o(fc_cls), .fc_vc_o(fc_vc),
        .fc_hdr_o(fc_hdr), .fc_data_o(fc_data), .crc_err_o(crc_err), .len_err_o(len_err)
`ifdef DLLP_RX_STATS_EN
        , .ack_cnt_o(ack_cnt), .nak_cnt_o(nak_cnt), .fc_cnt_o(fc_cnt), .err_cnt_o(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fc_seen = 0;
    int an_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference DLLP CRC in reflected (right-shift) form over bytes 0..3.
    // Returns {byte4, byte5}.
    function automatic logic [15:0] dllp_crc(input logic [7:0] b0, b1, b2, b3);
        logic [31:0] msg;
        logic [15:0] r;
        msg = {b3, b2, b1, b0};
        r   = 16'hFFFF;
        for (int i = 0; i < 32; i++) begin
            if (r[0] ^ msg[i]) r = (r >> 1) ^ 16'hD008;
            else               r = r >> 1;
        end
        return {~r[7:0], ~r[15:8]};
    endfunction

    // ---------------- behavioural model ----------------
    logic [7:0]  mq[$];
    logic        e_an_v = 0, e_nak = 0, e_fc_v = 0, e_crc = 0, e_len = 0;
    logic [11:0] e_seq = 0, e_data = 0;
    logic [1:0]  e_kind = 0, e_cls = 0;
    logic [2:0]  e_vc = 0;
    logic [7:0]  e_hdr = 0;
    logic [15:0] e_ack_cnt = 0, e_nak_cnt = 0, e_fc_cnt = 0, e_err_cnt = 0;

    function automatic logic [15:0] sat(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [7:0] t, b1, b2, b3;
        logic [15:0] c;
        int hi;
        if (rst) begin
            mq.delete();
            e_an_v = 0; e_nak = 0; e_seq = 0; e_fc_v = 0; e_kind = 0; e_cls = 0;
            e_vc = 0; e_hdr = 0; e_data = 0; e_crc = 0; e_len = 0;
            e_ack_cnt = 0; e_nak_cnt = 0; e_fc_cnt = 0; e_err_cnt = 0;
        end else begin
            e_an_v = 0; e_fc_v = 0; e_crc = 0; e_len = 0;
            if (tvalid && tuser[0]) begin
                for (int i = 0; i < 4; i++) if (tkeep[i]) mq.push_back(tdata[8*i +: 8]);
                if (tlast) begin
                    if (link != DL_INACTIVE) begin
                        if (mq.size() != 6) e_len = 1;
                        else begin
                            t = mq[0]; b1 = mq[1]; b2 = mq[2]; b3 = mq[3];
                            c = dllp_crc(t, b1, b2, b3);
                            hi = int'(t[7:4]);
                            if (c != {mq[4], mq[5]}) e_crc = 1;
                            else if (t == 8'h00 || t == 8'h10) begin
                                e_an_v = 1; e_nak = (t == 8'h10); e_seq = {b2[3:0], b3};
                            end else if ((hi >= 4 && hi <= 6) || (hi >= 8 && hi <= 10) || (hi >= 12 && hi <= 14)) begin
                                e_fc_v = 1;
                                e_kind = (hi < 8) ? 2'd0 : (hi < 12) ? 2'd2 : 2'd1;
                                e_cls  = 2'(hi % 4);
                                e_vc   = t[2:0];
                                e_hdr  = {b1[5:0], b2[7:6]};
                                e_data = {b2[3:0], b3};
                            end
                        end
                    end
                    mq.delete();
                end
            end
            e_ack_cnt = sat(e_ack_cnt, e_an_v && !e_nak);
            e_nak_cnt = sat(e_nak_cnt, e_an_v && e_nak);
            e_fc_cnt  = sat(e_fc_cnt, e_fc_v);
            e_err_cnt = sat(e_err_cnt, e_crc || e_len);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("tready", 64'(tready), 64'(!rst));
        chk("ack_nak", 64'({an_v, an_nak, an_seq}), 64'({e_an_v, e_nak, e_seq}));
        chk("fc", 64'({fc_v, fc_kind, fc_cls, fc_vc, fc_hdr, fc_data}),
                  64'({e_fc_v, e_kind, e_cls, e_vc, e_hdr, e_data}));
        chk("errs", 64'({crc_err, len_err}), 64'({e_crc, e_len}));
`ifdef DLLP_RX_STATS_EN
        chk("stats", {ack_cnt, nak_cnt, fc_cnt, err_cnt}, {e_ack_cnt, e_nak_cnt, e_fc_cnt, e_err_cnt});
`endif
        if (fc_v) fc_seen++;
        if (an_v) an_seen++;
    end

    // ---------------- driver ----------------
    logic [7:0] dl [16];
    int         dl_n;

    task automatic mk(input logic [7:0] b0, b1, b2, b3);
        logic [15:0] c;
        c = dllp_crc(b0, b1, b2, b3);
        dl[0] = b0; dl[1] = b1; dl[2] = b2; dl[3] = b3;
        dl[4] = c[15:8]; dl[5] = c[7:0];
        dl_n = 6;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    // Send dl[0..dl_n-1]; full = 4 bytes per beat, else random split; optional gaps.
    task automatic send(input bit full, input bit gaps);
        int pos, rem, k, mx;
        pos = 0;
        while (pos < dl_n) begin
            rem = dl_n - pos;
            mx  = (rem > 4) ? 4 : rem;
            k   = full ? mx : int'($urandom_range(1, mx));
            tdata = '0; tkeep = '0;
            for (int i = 0; i < k; i++) begin
                tdata[8*i +: 8] = dl[pos+i];
                tkeep[i] = 1'b1;
            end
            tvalid = 1'b1;
            tlast  = (pos + k == dl_n);
            pos += k;
            @(posedge clk); #2;
            tvalid = 1'b0; tlast = 1'b0;
            if (gaps && pos < dl_n && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fc0, an0, sel, r, n;
        logic [3:0] his [9];
        logic [7:0] pm [5];
        logic [7:0] b0;
        his = '{4'h4, 4'h5, 4'h6, 4'hC, 4'hD, 4'hE, 4'h8, 4'h9, 4'hA};
        pm  = '{8'h20, 8'h21, 8'h24, 8'h30, 8'h31};

        rst = 1'b1;
        @(negedge clk);
        chk("reset_outputs", 64'({tready, an_v, an_nak, an_seq, fc_v, fc_kind, fc_cls, fc_vc,
                                   fc_hdr, fc_data, crc_err, len_err}), 64'd0);
        idle(2);
        rst = 1'b0;
        idle(2);

        // Ack seq 0x123
        mk(8'h00, 8'h00, 8'h01, 8'h23); send(1, 0);
        @(negedge clk);
        chk("ack_valid", 64'({an_v, an_nak}), 64'b10);
        chk("ack_seq", 64'(an_seq), 64'h123);
        chk("ack_noerr", 64'({crc_err, len_err, fc_v}), 64'd0);
        chk("model_ack_seq", 64'({e_an_v, e_seq}), 64'h1123);
        idle(1);

        // UpdateFC NP vc1
        mk(8'h91, 8'h2A, 8'hC5, 8'h67); send(1, 0);
        @(negedge clk);
        chk("updfc_fields", 64'({fc_v, fc_kind, fc_cls, fc_vc}), 64'({1'b1, 2'd2, 2'd1, 3'd1}));
        chk("updfc_hdr", 64'(fc_hdr), 64'hAB);
        chk("updfc_data", 64'(fc_data), 64'h567);
        chk("model_updfc", 64'({e_hdr, e_data}), 64'hAB567);
        idle(1);

        // Nak with corrupted CRC
        mk(8'h10, 8'h00, 8'h00, 8'hFF); dl[5] = dl[5] ^ 8'h01; send(1, 0);
        @(negedge clk);
        chk("crc_err_strobe", 64'({crc_err, len_err, an_v}), 64'b100);
        idle(1);

        // 5-byte and 8-byte DLLPs
        mk(8'h00, 8'h00, 8'h01, 8'h23); dl_n = 5; send(1, 0);
        @(negedge clk);
        chk("len5_err", 64'({len_err, crc_err, an_v}), 64'b100);
        idle(1);
        mk(8'h00, 8'h00, 8'h01, 8'h23); dl[6] = 8'hAA; dl[7] = 8'h55; dl_n = 8; send(1, 0);
        @(negedge clk);
        chk("len8_err", 64'({len_err, crc_err, an_v}), 64'b100);
        idle(1);

        // Back-to-back InitFC1 P/NP/Cpl, InitFC2 P, then a DLLP cut by reset
        fc0 = fc_seen; an0 = an_seen;
        mk(8'h40, 8'h01, 8'h02, 8'h03); send(1, 0);
        mk(8'h51, 8'h11, 8'h12, 8'h13); send(1, 0);
        mk(8'h62, 8'h21, 8'h22, 8'h23); send(1, 0);
        mk(8'hC3, 8'h31, 8'h32, 8'h33); send(1, 0);
        idle(1);
        mk(8'h00, 8'h00, 8'h04, 8'h56);
        tdata = {dl[3], dl[2], dl[1], dl[0]}; tkeep = 4'hF; tvalid = 1'b1; tlast = 1'b0;
        #1 rst = 1'b1;
        @(posedge clk); #2;
        tvalid = 1'b0;
        idle(1);
        rst = 1'b0;
        idle(4);
        chk("b2b_fc_count", 64'(fc_seen - fc0), 64'd4);
        chk("cut_no_ack", 64'(an_seen - an0), 64'd0);

        // Inactive link: no strobe
        link = DL_INACTIVE;
        mk(8'h00, 8'h00, 8'h07, 8'h89); send(1, 0);
        @(negedge clk);
        chk("inactive_quiet", 64'({an_v, fc_v, crc_err, len_err}), 64'd0);
        idle(1);
        link = DL_ACTIVE;

        // Statistics scenario from a clean reset
        rst = 1'b1; idle(2); rst = 1'b0; idle(1);
        an0 = an_seen;
        for (int i = 0; i < 3; i++) begin mk(8'h00, 8'h00, 8'h00, 8'(i)); send(0, 1); end
        mk(8'h10, 8'h00, 8'h00, 8'hFF); send(0, 1);
        mk(8'h10, 8'h00, 8'h00, 8'hFF); dl[4] = dl[4] ^ 8'h80; send(0, 1);
        mk(8'h00, 8'h00, 8'h00, 8'h01); dl_n = 7; send(0, 1);
        idle(2);
        @(negedge clk);
        chk("stats_an_seen", 64'(an_seen - an0), 64'd4);
`ifdef DLLP_RX_STATS_EN
        chk("stats_ack", 64'(ack_cnt), 64'd3);
        chk("stats_nak", 64'(nak_cnt), 64'd1);
        chk("stats_err", 64'(err_cnt), 64'd2);
`endif
        idle(1);

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      b0 = 8'h00;
            else if (sel == 1) b0 = 8'h10;
            else if (sel <= 6) b0 = {his[$urandom_range(0, 8)], 1'b0, 3'($urandom)};
            else if (sel == 7) b0 = pm[$urandom_range(0, 4)];
            else               b0 = 8'($urandom);
            mk(b0, 8'($urandom), 8'($urandom), 8'($urandom));
            r = int'($urandom_range(0, 19));
            if (r == 0)      dl[4] = dl[4] ^ 8'(1 << $urandom_range(0, 7));
            else if (r == 1) dl[5] = dl[5] ^ 8'(1 << $urandom_range(0, 7));
            else if (r <= 4) begin
                n = int'($urandom_range(1, 9));
                if (n >= 6) n++;
                for (int i = 6; i < n; i++) dl[i] = 8'($urandom);
                dl_n = n;
            end
            r = int'($urandom_range(0, 9));
            link = (r == 0) ? DL_INACTIVE : (r < 5) ? DL_INIT : DL_ACTIVE;
            send(0, 1);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        end
        link = DL_ACTIVE;
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
